// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, taken-branch flushes and memory-wait freezes with timeout.
// Optional perf counters are built only when HAZCTL_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       IFID_RS1,
  input  logic [3:0]       IFID_RS2,
  input  logic [3:0]       IDEX_RD,
  input  logic             IDEX_memRead,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             EXMEM_write,
  output logic             MEMWB_bubble,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERR     = 2'd2
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_err_q, mem_err_d;
  logic       memstall_s;
  logic       loaduse_s;

  assign memstall_s = mem_req && !mem_ack && (state_q != ST_ERR);
  assign loaduse_s  = IDEX_memRead && (IDEX_RD != 4'd0) &&
                      ((IDEX_RD == IFID_RS1) || (IDEX_RD == IFID_RS2));

  // Pipeline enables and strobes, priority memstall > branch > load-use.
  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IDEX_write   = 1'b1;
    EXMEM_write  = 1'b1;
    MEMWB_bubble = 1'b0;
    IDEX_bubble  = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    if (state_q == ST_ERR) begin
      PC_write = 1'b1;
    end else if (memstall_s) begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IDEX_write   = 1'b0;
      EXMEM_write  = 1'b0;
      MEMWB_bubble = 1'b1;
    end else if (branch_taken) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (loaduse_s) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end else begin
      PC_write = 1'b1;
    end
  end

  // Next state, wait counter and sticky timeout flag.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (memstall_s) begin
          state_d = ST_MEMWAIT;
          wait_d  = 8'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (!memstall_s) begin
          state_d = ST_RUN;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = ST_ERR;
          wait_d    = 8'd0;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZCTL_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Saturating increments; counters hold at all-ones.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!PC_write && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
    if (IFID_flush && (flush_q != {CNT_W{1'b1}})) begin
      flush_d = flush_q + CNT_W'(1);
    end else begin
      flush_d = flush_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= {CNT_W{1'b0}};
      flush_q <= {CNT_W{1'b0}};
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall/flush controller for the 16-bit RISC-V core. It is the stall side of hazard resolution: the forwarding unit resolves RAW hazards by bypass, and this block handles the hazards that bypass cannot.
- Load-use hazards: inserts a bubble.
- Taken branches resolved in EX: flushes IF/ID and ID/EX.
- Multi-cycle data-memory accesses: freezes the pipeline through a req/ack handshake, with a timeout.

It sits beside the ID stage and drives the write enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum MEMWAIT cycles before mem_err; legal range 1..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IFID_RS1  in  4  rs1 of the instruction in ID.
- IFID_RS2  in  4  rs2 of the instruction in ID.
- IDEX_RD  in  4  rd of the instruction in EX.
- IDEX_memRead  in  1  instruction in EX is a load.
- branch_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ack  in  1  data memory completes the access this cycle.
- PC_write  out  1  PC update enable.
- IFID_write  out  1  IF/ID register enable.
- IDEX_write  out  1  ID/EX register enable.
- EXMEM_write  out  1  EX/MEM register enable.
- MEMWB_bubble  out  1  load NOP into MEM/WB (regWrite=0).
- IDEX_bubble  out  1  load NOP into ID/EX.
- IFID_flush  out  1  clear IF/ID.
- IDEX_flush  out  1  clear ID/EX.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  total stalled cycles.
- flush_count  out  CNT_W  number of branch flushes.

## Operation
FSM states: RUN, MEMWAIT, ERR. Reset state is RUN, and all counters and mem_err are 0.

Signal definitions:
- memstall = mem_req && !mem_ack && state!=ERR.
- loaduse = IDEX_memRead && IDEX_RD!=0 && (IDEX_RD==IFID_RS1 || IDEX_RD==IFID_RS2).

Priority in RUN and MEMWAIT is memstall > branch_taken > loaduse.
- **memstall:**
  - PC_write, IFID_write, IDEX_write and EXMEM_write are 0; MEMWB_bubble=1.
  - All other strobes are 0; any branch or load-use is held and re-evaluated later.
  - Next state is MEMWAIT.
- **branch_taken (no memstall):** IFID_flush=1 and IDEX_flush=1; all write enables are 1. A load-use in the same cycle is ignored because the ID instruction is being flushed.
- **loaduse (no memstall, no branch):** PC_write=0, IFID_write=0, IDEX_bubble=1; IDEX_write=1 and EXMEM_write=1.
- **None of the above:** all write enables are 1 and all strobes are 0.

MEMWAIT:
- A wait counter counts cycles spent in MEMWAIT. It is cleared on entry and on exit.
- mem_ack=1 returns to RUN at the next edge. In the ack cycle the outputs follow the RUN rules.
- If the counter reaches MEM_TIMEOUT with no ack, the FSM goes to ERR and mem_err=1.

ERR:
- Pipeline runs freely: all enables are 1 and mem_req is ignored.
- mem_err stays 1 until rst_n is asserted.

Counters:
- stall_cycles increments on every cycle where PC_write=0.
- flush_count increments on every cycle where IFID_flush=1.
- Both saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the current state and inputs, with zero-cycle latency. They take effect at the next rising edge.
- The FSM, wait counter, mem_err and perf counters are registered. rst_n asserted mid-operation forces RUN and clears everything asynchronously.
- A load-use stall is exactly 1 cycle. The inserted bubble clears IDEX_memRead, so the condition drops without further state.
- A memory access with ack in the request cycle costs 0 stall cycles. Ack after N wait cycles costs N stall cycles.
- Reset output values, with all inputs at 0: PC_write, IFID_write, IDEX_write, EXMEM_write are 1. All other outputs are 0.

## Configuration
- HAZCTL_PERF_EN defined: stall_cycles and flush_count are implemented as described.
- HAZCTL_PERF_EN undefined: no counter registers are built, and both outputs are tied to 0. Stall and flush behaviour is unchanged.

## Test plan
- **Load-use:** IDEX_memRead=1, IDEX_RD=5, IFID_RS2=5 for 1 cycle -> PC_write=0, IFID_write=0, IDEX_bubble=1 that cycle; stall_cycles 0->1.
- **rd=0:** IDEX_memRead=1, IDEX_RD=0, IFID_RS1=0 -> no stall, all enables 1.
- **Branch over load-use:** branch_taken=1 together with a load-use match -> IFID_flush=IDEX_flush=1, PC_write=1, flush_count=1, stall_cycles unchanged.
- **Memory wait:** mem_req=1 with mem_ack low for 3 cycles, then high -> 3 cycles with all enables 0 and MEMWB_bubble=1; RUN on the ack cycle; stall_cycles=3.
- **Timeout (MEM_TIMEOUT=4):** mem_req held, no ack -> ERR after 4 MEMWAIT cycles; mem_err=1 and all enables 1. Reset mid-ERR -> mem_err=0, state RUN.
- **Saturation (CNT_W=4):** 20 consecutive load-use stalls -> stall_cycles stops at 15. With HAZCTL_PERF_EN undefined, both counters read 0 throughout.
